// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC generation, instruction-memory request issue and in-order response buffering.
// Define FETCH_PERF_EN to add the perf_fetched / perf_bubbles counters.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);
  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;
  state_t state;
  logic [31:0] pc;
  logic [CW-1:0] outstanding, buf_count, drop_count, drop_next;
  logic [AW-1:0] tag_wp, tag_rp, buf_wp, buf_rp;
  logic [31:0] tag_mem [MAX_OUTSTANDING];
  logic [31:0] buf_pc [MAX_OUTSTANDING];
  logic [31:0] buf_ins [MAX_OUTSTANDING];
  logic [CW:0] used;
  logic issue, resp, push, pop;
  // credits come from registered counts only, so a same-cycle pop never frees one
  assign used = {1'b0, outstanding} + {1'b0, buf_count};
  assign mem_req = state == RUN && !redirect_valid && used < (CW+1)'(MAX_OUTSTANDING);
  assign mem_addr = pc;
  assign issue = mem_req && mem_gnt;
  assign resp = mem_rvalid && outstanding != '0;
  assign push = resp && state == RUN && !redirect_valid;
  assign pop = !redirect_valid && !stall && buf_count != '0;
  assign drop_next = outstanding - CW'(resp);
  always_ff @(posedge clock) begin
    if (issue) tag_mem[tag_wp] <= pc;
    if (push) begin
      buf_pc[buf_wp] <= tag_mem[tag_rp];
      buf_ins[buf_wp] <= mem_rdata;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      pc <= RESET_PC;
      outstanding <= '0;
      drop_count <= '0;
      buf_count <= '0;
      tag_wp <= '0;
      tag_rp <= '0;
      buf_wp <= '0;
      buf_rp <= '0;
      instruction <= NOP_INSTR;
      instr_pc <= '0;
      instr_valid <= 1'b0;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
      tag_wp <= '0;
      tag_rp <= '0;
      buf_wp <= '0;
      buf_rp <= '0;
      buf_count <= '0;
      outstanding <= drop_next;
      drop_count <= drop_next;
      state <= drop_next != '0 ? DRAIN : RUN;
      instruction <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else begin
      if (state == BOOT) state <= RUN;
      if (state == DRAIN && resp) begin
        drop_count <= drop_count - CW'(1);
        if (drop_count == CW'(1)) state <= RUN;
      end
      if (issue) begin
        pc <= pc + 32'd4;
        tag_wp <= tag_wp + AW'(1);
      end
      if (push) begin
        tag_rp <= tag_rp + AW'(1);
        buf_wp <= buf_wp + AW'(1);
      end
      if (pop) buf_rp <= buf_rp + AW'(1);
      outstanding <= outstanding + CW'(issue) - CW'(resp);
      buf_count <= buf_count + CW'(push) - CW'(pop);
      if (!stall) begin
        instruction <= pop ? buf_ins[buf_rp] : NOP_INSTR;
        instr_valid <= pop;
        if (pop) instr_pc <= buf_pc[buf_rp];
      end
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else if (!stall) begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_bubbles <= perf_bubbles + 32'(!pop);
    end
  end
`endif
endmodule
